bcd_clock_fmt: RTL and testbench

Sequential time-of-day keeper. It keeps an internal 24h BCD HH:MM:SS count and formats it for the 7-segment display path in either 24h or 12h (AM/PM) mode. It provides a button-driven set-mode FSM with digit blinking, so it replaces the purely combinational format stage with a complete clock core. It sits between the button debouncers and the display multiplexer.

---
 rtl/clock_pkg.sv | 51 +++++
 rtl/hour_fmt_12h.sv | 28 ++
 rtl/bcd_clock_fmt.sv | 184 ++++++++++++++++++
 tb/tb_bcd_clock_fmt.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types, limits and BCD step helpers for the time-of-day clock core.
package clock_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t tens;
    bcd_digit_t units;
  } bcd_pair_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2
  } set_state_t;

  localparam bcd_pair_t MAX_HOUR    = 8'h23;
  localparam bcd_pair_t MAX_MIN_SEC = 8'h59;
  localparam bcd_pair_t NOON        = 8'h12;
  localparam bcd_pair_t BCD_ZERO    = 8'h00;

  // Step a two-digit BCD value up by one, wrapping from max back to 00.
  function automatic bcd_pair_t bcd_inc_wrap(input bcd_pair_t val, input bcd_pair_t max);
    bcd_pair_t res;
    if (val == max) begin
      res = BCD_ZERO;
    end else if (val.units == 4'd9) begin
      res.tens  = val.tens + 4'd1;
      res.units = 4'd0;
    end else begin
      res.tens  = val.tens;
      res.units = val.units + 4'd1;
    end
    return res;
  endfunction

  function automatic bcd_pair_t bcd_dec_wrap(input bcd_pair_t val, input bcd_pair_t max);
    bcd_pair_t res;
    if (val == BCD_ZERO) begin
      res = max;
    end else if (val.units == 4'd0) begin
      res.tens  = val.tens - 4'd1;
      res.units = 4'd9;
    end else begin
      res.tens  = val.tens;
      res.units = val.units - 4'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/hour_fmt_12h.sv
// Combinational 24h -> 12h hour conversion with PM flag (00 shows as 12 AM).
module hour_fmt_12h
  import clock_pkg::*;
(
  input  bcd_pair_t hour_24,
  output bcd_pair_t hour_12,
  output logic      pm
);

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    hour_12 = hour_24;
    pm      = (hour_24 >= NOON);
    if (hour_24 == BCD_ZERO) begin
      hour_12 = NOON;
    end else if (hour_24 > NOON) begin
      // BCD subtract of 12: borrow from the tens digit when units < 2.
      if (hour_24.units >= 4'd2) begin
        hour_12.tens  = hour_24.tens - 4'd1;
        hour_12.units = hour_24.units - 4'd2;
      end else begin
        hour_12.tens  = hour_24.tens - 4'd2;
        hour_12.units = hour_24.units + 4'd8;
      end
    end
  end

endmodule

// File: rtl/bcd_clock_fmt.sv
// Time-of-day keeper: BCD HH:MM:SS counter, button-driven set FSM with digit blink,
// and registered 24h/12h formatting for the 7-segment display path.
module bcd_clock_fmt
  import clock_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = 1,
  parameter int BLINK_HZ    = 2,
  parameter int SUPPRESS_LZ = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        toggle_ampm,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_dec,
  output logic [23:0] BCD_out,
  output logic        pm_flag,
  output logic [5:0]  blank_mask,
  output logic        sec_tick,
  output logic        set_active
);

  localparam int TICK_TC  = CLK_FREQ_HZ / TICK_HZ - 1;
  localparam int BLINK_HP = CLK_FREQ_HZ / (2 * BLINK_HZ);
  localparam int PRESC_W  = (TICK_TC < 1) ? 1 : $clog2(TICK_TC + 1);
  localparam int BLINK_W  = (BLINK_HP < 2) ? 1 : $clog2(BLINK_HP);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_TC);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HP - 1);

  if ((CLK_FREQ_HZ % TICK_HZ) != 0 || (CLK_FREQ_HZ % (2 * BLINK_HZ)) != 0) begin : g_param_check
    $error("bcd_clock_fmt: CLK_FREQ_HZ must be divisible by TICK_HZ and by 2*BLINK_HZ");
  end

  set_state_t         state_q, state_d;
  bcd_pair_t          hour_q, hour_d;
  bcd_pair_t          min_q, min_d;
  bcd_pair_t          sec_q, sec_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_ph_q, blink_ph_d;
  logic               tick_q, tick_d;
  logic               sec_tick_q, sec_tick_d;
  logic [23:0]        bcd_q, bcd_d;
  logic               pm_q, pm_d;
  logic [5:0]         blank_q, blank_d;

  logic      inc_only, dec_only;
  bcd_pair_t hour_12, disp_hour;
  logic      pm_12, lead_zero;

  assign inc_only = btn_inc & ~btn_dec;
  assign dec_only = btn_dec & ~btn_inc;

  // Time keeping, set FSM and blink generator.
  always_comb begin
    state_d     = state_q;
    hour_d      = hour_q;
    min_d       = min_q;
    sec_d       = sec_q;
    presc_d     = presc_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    tick_d      = 1'b0;

    unique case (state_q)
      RUN: begin
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          tick_d  = 1'b1;
          sec_d   = bcd_inc_wrap(sec_q, MAX_MIN_SEC);
          if (sec_q == MAX_MIN_SEC) begin
            min_d = bcd_inc_wrap(min_q, MAX_MIN_SEC);
            if (min_q == MAX_MIN_SEC) begin
              hour_d = bcd_inc_wrap(hour_q, MAX_HOUR);
            end
          end
        end else begin
          presc_d = presc_q + PRESC_W'(1);
        end
        if (btn_mode) begin
          state_d = SET_H;
        end
      end
      SET_H: begin
        if (btn_mode) begin
          state_d = SET_M;
        end else if (inc_only) begin
          hour_d = bcd_inc_wrap(hour_q, MAX_HOUR);
        end else if (dec_only) begin
          hour_d = bcd_dec_wrap(hour_q, MAX_HOUR);
        end
      end
      SET_M: begin
        if (btn_mode) begin
          // Leaving set mode restarts the second so the next tick is a full period away.
          state_d = RUN;
          sec_d   = BCD_ZERO;
          presc_d = '0;
        end else if (inc_only) begin
          min_d = bcd_inc_wrap(min_q, MAX_MIN_SEC);
        end else if (dec_only) begin
          min_d = bcd_dec_wrap(min_q, MAX_MIN_SEC);
        end
      end
      default: state_d = RUN;
    endcase

    if (state_d != state_q) begin
      blink_cnt_d = '0;
      blink_ph_d  = 1'b0;
    end else if (state_q != RUN) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  hour_fmt_12h u_hour_fmt (
    .hour_24 (hour_q),
    .hour_12 (hour_12),
    .pm      (pm_12)
  );

  // Display formatting; registered below so outputs trail the time register by one cycle.
  always_comb begin
    disp_hour  = toggle_ampm ? hour_12 : hour_q;
    lead_zero  = (SUPPRESS_LZ != 0) && toggle_ampm && (disp_hour.tens == 4'd0);
    bcd_d      = {disp_hour, min_q, sec_q};
    pm_d       = toggle_ampm & pm_12;
    sec_tick_d = tick_q;
    blank_d    = 6'b000000;
    blank_d[5] = lead_zero;
    unique case (state_q)
      SET_H: begin
        blank_d[5] = lead_zero | blink_ph_q;
        blank_d[4] = blink_ph_q;
      end
      SET_M:   blank_d[3:2] = {2{blink_ph_q}};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      hour_q      <= BCD_ZERO;
      min_q       <= BCD_ZERO;
      sec_q       <= BCD_ZERO;
      presc_q     <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      tick_q      <= 1'b0;
      sec_tick_q  <= 1'b0;
      bcd_q       <= 24'h0;
      pm_q        <= 1'b0;
      blank_q     <= 6'b000000;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      presc_q     <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      tick_q      <= tick_d;
      sec_tick_q  <= sec_tick_d;
      bcd_q       <= bcd_d;
      pm_q        <= pm_d;
      blank_q     <= blank_d;
    end
  end

  assign BCD_out    = bcd_q;
  assign pm_flag    = pm_q;
  assign blank_mask = blank_q;
  assign sec_tick   = sec_tick_q;
  assign set_active = (state_q != RUN);

endmodule

// File: tb/tb_bcd_clock_fmt.sv
// Self-checking bench for bcd_clock_fmt: seconds-of-day reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_bcd_clock_fmt;

  localparam int CLK_FREQ = 10;
  localparam int TICK     = 1;
  localparam int BLINK    = 1;
  localparam int TC       = CLK_FREQ / TICK - 1;
  localparam int HALF     = CLK_FREQ / (2 * BLINK);

  logic        clk = 1'b0;
  logic        rst;
  logic        toggle_ampm;
  logic        btn_mode, btn_inc, btn_dec;
  logic [23:0] BCD_out;
  logic        pm_flag;
  logic [5:0]  blank_mask;
  logic        sec_tick;
  logic        set_active;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_clock_fmt #(
    .CLK_FREQ_HZ (CLK_FREQ),
    .TICK_HZ     (TICK),
    .BLINK_HZ    (BLINK),
    .SUPPRESS_LZ (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .toggle_ampm (toggle_ampm),
    .btn_mode    (btn_mode),
    .btn_inc     (btn_inc),
    .btn_dec     (btn_dec),
    .BCD_out     (BCD_out),
    .pm_flag     (pm_flag),
    .blank_mask  (blank_mask),
    .sec_tick    (sec_tick),
    .set_active  (set_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // ---------------- reference model (seconds-of-day arithmetic) ----------------
  int m_h = 0, m_m = 0, m_s = 0, m_presc = 0, m_st = 0, m_set_cyc = 0;
  bit m_tick_pend = 0;
  logic [23:0] e_bcd   = '0;
  logic        e_pm    = 1'b0;
  logic [5:0]  e_blank = '0;
  logic        e_tick  = 1'b0;
  logic        e_set   = 1'b0;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic model_reset();
    m_h = 0; m_m = 0; m_s = 0; m_presc = 0; m_st = 0; m_set_cyc = 0; m_tick_pend = 0;
    e_bcd = '0; e_pm = 1'b0; e_blank = '0; e_tick = 1'b0; e_set = 1'b0;
  endtask

  task automatic model_step();
    int  hd, tod;
    bit  inc1, dec1, ph;
    hd      = toggle_ampm ? ((m_h % 12 == 0) ? 12 : m_h % 12) : m_h;
    ph      = ((m_set_cyc / HALF) % 2) == 1;
    e_bcd   = {to_bcd(hd), to_bcd(m_m), to_bcd(m_s)};
    e_pm    = toggle_ampm && (m_h >= 12);
    e_blank = '0;
    e_blank[5] = toggle_ampm && (hd < 10);
    if (m_st == 1 && ph) e_blank[5:4] = 2'b11;
    if (m_st == 2 && ph) e_blank[3:2] = 2'b11;
    e_tick      = m_tick_pend;
    m_tick_pend = (m_st == 0) && (m_presc == TC);
    inc1 = btn_inc && !btn_dec;
    dec1 = btn_dec && !btn_inc;
    case (m_st)
      0: begin
        if (m_presc == TC) begin
          m_presc = 0;
          tod = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
          m_h = tod / 3600;
          m_m = (tod / 60) % 60;
          m_s = tod % 60;
        end else begin
          m_presc++;
        end
        if (btn_mode) begin m_st = 1; m_set_cyc = 0; end
      end
      1: begin
        if (btn_mode) begin m_st = 2; m_set_cyc = 0; end
        else begin
          m_set_cyc++;
          if (inc1) m_h = (m_h + 1) % 24;
          else if (dec1) m_h = (m_h + 23) % 24;
        end
      end
      default: begin
        if (btn_mode) begin m_st = 0; m_s = 0; m_presc = 0; end
        else begin
          m_set_cyc++;
          if (inc1) m_m = (m_m + 1) % 60;
          else if (dec1) m_m = (m_m + 59) % 60;
        end
      end
    endcase
    e_set = (m_st != 0);
  endtask

  initial begin : model_proc
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  initial begin : compare_proc
    forever begin
      @(posedge clk);
      #1;
      check("cyc_bcd", BCD_out, e_bcd);
      check("cyc_pm", pm_flag, e_pm);
      check("cyc_blank", blank_mask, e_blank);
      check("cyc_sec_tick", sec_tick, e_tick);
      check("cyc_set_active", set_active, e_set);
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  task automatic pulse(input bit mode, input bit inc, input bit dec);
    @(negedge clk);
    btn_mode = mode; btn_inc = inc; btn_dec = dec;
    @(negedge clk);
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin : stim
    int cyc, ticks;
    bit got;
    rst = 1'b1; toggle_ampm = 1'b1;
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_bcd", BCD_out, 24'h000000);
    check("rst_set_active", set_active, 1'b0);

    // 1: first tick after reset, 12h mode shows 12:00:01 AM
    rst = 1'b0;
    cyc = 0; got = 0;
    while (cyc < 20 && !got) begin
      settle();
      cyc++;
      if (sec_tick) got = 1;
    end
    check("t1_tick_cycle", cyc, 11);
    check("t1_bcd", BCD_out, 24'h120001);
    check("t1_pm", pm_flag, 1'b0);
    check("t1_blank", blank_mask, 6'b000000);

    // 2: set 23:59, exit, run to midnight rollover
    pulse(1, 0, 0);
    pulse(0, 0, 1);
    pulse(1, 0, 0);
    pulse(0, 0, 1);
    @(negedge clk); btn_mode = 1'b1; toggle_ampm = 1'b0;
    @(negedge clk); btn_mode = 1'b0;
    settle();
    check("t2_exit_time", BCD_out, 24'h235900);
    check("t2_exit_run", set_active, 1'b0);
    ticks = 0; cyc = 0;
    while (ticks < 60 && cyc < 700) begin
      settle();
      cyc++;
      if (sec_tick) ticks++;
    end
    check("t2_tick_count", ticks, 60);
    check("t2_rollover", BCD_out, 24'h000000);

    // 3: 12h conversion of 12, 13, 00 and the 24h view of 13
    @(negedge clk); toggle_ampm = 1'b1;
    pulse(1, 0, 0);
    repeat (12) pulse(0, 1, 0);
    settle();
    check("t3_h12_hour", BCD_out[23:16], 8'h12);
    check("t3_h12_pm", pm_flag, 1'b1);
    pulse(0, 1, 0);
    settle();
    check("t3_h13_hour", BCD_out[23:16], 8'h01);
    check("t3_h13_pm", pm_flag, 1'b1);
    check("t3_h13_lz", blank_mask[5], 1'b1);
    repeat (11) pulse(0, 1, 0);
    settle();
    check("t3_h00_hour", BCD_out[23:16], 8'h12);
    check("t3_h00_pm", pm_flag, 1'b0);
    repeat (11) pulse(0, 0, 1);
    @(negedge clk); toggle_ampm = 1'b0;
    #1;
    check("t3_toggle_pre_edge", BCD_out[23:16], 8'h01);
    settle();
    check("t3_h13_24h_hour", BCD_out[23:16], 8'h13);
    check("t3_h13_24h_pm", pm_flag, 1'b0);

    // 4: simultaneous buttons and RUN-mode inc
    repeat (8) pulse(0, 0, 1);
    settle();
    check("t4_hour05", BCD_out[23:16], 8'h05);
    pulse(0, 1, 1);
    settle();
    check("t4_inc_dec_both", BCD_out[23:16], 8'h05);
    pulse(1, 1, 0);
    settle();
    check("t4_mode_wins", BCD_out[23:8], 16'h0500);
    check("t4_still_set", set_active, 1'b1);
    pulse(0, 0, 1);
    settle();
    check("t4_min_wrap_dn", BCD_out[23:8], 16'h0559);
    pulse(0, 1, 0);
    settle();
    check("t4_min_wrap_up", BCD_out[23:8], 16'h0500);
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    settle();
    check("t4_run_inc_ignored", BCD_out[23:8], 16'h0500);
    check("t4_run", set_active, 1'b0);

    // 5: blink phases in SET_H then SET_M
    @(negedge clk); btn_mode = 1'b1;
    @(negedge clk); btn_mode = 1'b0;
    for (int i = 0; i < 15; i++) begin
      settle();
      check("t5_blink_h", blank_mask[5:4], ((i / 5) % 2 == 1) ? 2'b11 : 2'b00);
    end
    @(negedge clk); btn_mode = 1'b1;
    @(negedge clk); btn_mode = 1'b0;
    for (int i = 0; i < 7; i++) begin
      settle();
      check("t5_blink_m", blank_mask[5:2], (i >= 5) ? 4'b0011 : 4'b0000);
    end

    // 6: asynchronous reset between edges
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_async_bcd", BCD_out, 24'h000000);
    check("t6_async_set_active", set_active, 1'b0);
    check("t6_async_blank", blank_mask, 6'b000000);
    check("t6_async_pm", pm_flag, 1'b0);
    check("t6_async_tick", sec_tick, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    settle();
    check("t6_post_run", set_active, 1'b0);
    check("t6_post_time", BCD_out, 24'h000000);
    repeat (15) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
